mips_trace_buffer: RTL and testbench
====================================

MIPS_TRACE_BUFFER -- requirements
Module: mips_trace_buffer

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, PC width.
REQ-002 SHALL have parameter DATA_W, default 32, instruction width.
REQ-003 SHALL have parameter DEPTH, default 16, entry count; a power of two, >=4.
REQ-004 SHALL have parameter POST_TRIG, default DEPTH/2, entries captured after the trigger entry; range 0..DEPTH-1.
REQ-005 SHALL have port MAX10_CLK1_50  in  1  sole clock; all logic on its rising edge.
REQ-006 SHALL have port KEY  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have port cap_valid  in  1  a retired instruction is present this cycle.
REQ-008 SHALL have ports cap_pc  in  ADDR_W  and  cap_instr  in  DATA_W  retired PC and instruction word.
REQ-009 SHALL have port arm  in  1  single-cycle pulse that starts or restarts a capture.
REQ-010 SHALL have port mode  in  1  0 = stop-on-trigger (circular), 1 = fill-once; sampled on arm.
REQ-011 SHALL have ports trig_en  in  1  and  trig_pc  in  ADDR_W  PC-match trigger; sampled on arm.
REQ-012 SHALL have ports out_valid  out  1,  out_ready  in  1,  out_pc  out  ADDR_W,  out_instr  out  DATA_W,  out_last  out  1  dump stream.
REQ-013 SHALL have ports busy  out  1,  triggered  out  1,  wrapped  out  1,  count  out  $clog2(DEPTH)+1  status.

Function
REQ-014 SHALL implement states IDLE, ARMED, POST, DUMP.
REQ-015 IDLE: no writes; arm -> ARMED; write pointer, count, triggered and wrapped cleared on that edge.
REQ-016 ARMED: each cap_valid writes {cap_pc,cap_instr} at the write pointer; the pointer increments modulo DEPTH; count saturates at DEPTH; wrapped sets on the first overwrite.
REQ-017 ARMED, mode=0: a written entry with trig_en=1 and cap_pc==trig_pc sets triggered and -> POST with post counter = POST_TRIG; POST_TRIG=0 -> DUMP directly.
REQ-018 ARMED, mode=1: the write that makes count==DEPTH -> DUMP; triggers ignored; wrapped stays 0.
REQ-019 POST: each write decrements the post counter; the write that takes it to 0 -> DUMP; further PC matches ignored.
REQ-020 DUMP: no writes; entries are presented oldest first, starting at (write pointer - count) mod DEPTH, count entries total.
REQ-021 out_valid SHALL assert on the cycle after DUMP entry; out_pc/out_instr/out_last SHALL be registered and stable while out_valid && !out_ready.
REQ-022 out_last=1 on the final entry only; its handshake -> IDLE with out_valid low on the next cycle; count is not modified by the dump.
REQ-023 arm in ARMED, POST or DUMP SHALL restart as in REQ-015 (abort); out_valid drops on the next cycle.
REQ-024 busy = (state != IDLE); count reflects valid entries, max DEPTH.
REQ-025 cap_valid and a transition on the same edge: the capture is written before the state changes (the trigger entry and the final post entry are stored).

Reset
REQ-026 KEY=0 SHALL immediately force IDLE and clear pointers, counters, out_valid, out_last, out_pc, out_instr, busy, triggered, wrapped and count to 0; storage array contents are not reset.
REQ-027 Reset mid-capture or mid-dump SHALL discard the trace; the first activity after release requires arm.

Structure
REQ-028 State encoding and mode constants SHALL live in shared package mips_trace_pkg.
REQ-029 Storage SHALL be one sub-module trace_ram (DEPTH x (ADDR_W+DATA_W), one write port, one synchronous read port).

Verification (DEPTH=8, POST_TRIG=3)
REQ-030 Arm mode=0, capture pc 0x00..0x10 step 4, then KEY=0 -> all outputs 0 and busy=0 at once; after release, cap_valid without arm writes nothing and count stays 0.
REQ-031 Arm mode=1, capture 10 PCs 0x00..0x24 step 4 -> count=8, wrapped=0; dump 0x00..0x1C, out_last on 0x1C.
REQ-032 Arm mode=0, trig_pc=0x40, capture 0x00..0x60 step 4 -> triggered=1, wrapped=1; dump 0x30..0x4C, out_last on 0x4C.
REQ-033 Arm mode=0, trig_pc=0x00, capture from 0x00 -> count=4; dump 0x00,0x04,0x08,0x0C.
REQ-034 During dump, out_ready=0 for 3 cycles -> out_valid=1 and out_pc/out_instr constant; no entry skipped or repeated.
REQ-035 arm pulse on the second dump beat -> out_valid=0 next cycle, state ARMED, count=0.

Source files
------------

// File: rtl/mips_trace_pkg.sv
// mips_trace_pkg: shared state encoding and capture mode constants for the trace buffer
package mips_trace_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_ARMED, ST_POST, ST_DUMP} state_t;
  localparam logic MODE_STOP = 1'b0;
  localparam logic MODE_FILL = 1'b1;
endpackage

// File: rtl/trace_ram.sv
// trace_ram: single write port, single synchronous read port trace storage
module trace_ram #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 64,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/mips_trace_buffer.sv
// mips_trace_buffer: retired-instruction trace capture with PC trigger and handshaked dump stream
module mips_trace_buffer
  import mips_trace_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 16,
  parameter int POST_TRIG = DEPTH / 2
) (
  input  logic                     MAX10_CLK1_50,
  input  logic                     KEY,
  input  logic                     cap_valid,
  input  logic [ADDR_W-1:0]        cap_pc,
  input  logic [DATA_W-1:0]        cap_instr,
  input  logic                     arm,
  input  logic                     mode,
  input  logic                     trig_en,
  input  logic [ADDR_W-1:0]        trig_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ADDR_W-1:0]        out_pc,
  output logic [DATA_W-1:0]        out_instr,
  output logic                     out_last,
  output logic                     busy,
  output logic                     triggered,
  output logic                     wrapped,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  state_t state, state_n;
  logic [AW-1:0] wr_ptr, post_cnt, rd_addr;
  logic [CW-1:0] idx;
  logic mode_r, trig_en_r;
  logic [ADDR_W-1:0] trig_pc_r;
  logic [ADDR_W+DATA_W-1:0] rd_data;
  logic we, full, trig_hit, fill_done, post_done, beat, first, rd_en;
  assign we        = cap_valid && !arm && (state == ST_ARMED || state == ST_POST);
  assign full      = count == CW'(DEPTH);
  assign trig_hit  = we && state == ST_ARMED && mode_r == MODE_STOP && trig_en_r && cap_pc == trig_pc_r;
  assign fill_done = we && state == ST_ARMED && mode_r == MODE_FILL && count == CW'(DEPTH - 1);
  assign post_done = we && state == ST_POST && post_cnt == AW'(1);
  assign beat      = out_valid && out_ready;
  assign first     = state == ST_DUMP && !out_valid;
  assign rd_en     = first || (beat && !out_last);
  assign rd_addr   = wr_ptr - count[AW-1:0] + idx[AW-1:0];
  assign busy      = state != ST_IDLE;
  assign {out_pc, out_instr} = rd_data;
  trace_ram #(.DEPTH(DEPTH), .WIDTH(ADDR_W + DATA_W)) u_ram (
    .clk   (MAX10_CLK1_50),
    .rst_n (KEY),
    .we    (we),
    .waddr (wr_ptr),
    .wdata ({cap_pc, cap_instr}),
    .re    (rd_en),
    .raddr (rd_addr),
    .rdata (rd_data)
  );
  always_ff @(posedge MAX10_CLK1_50 or negedge KEY) begin
    if (!KEY) state <= ST_IDLE;
    else state <= state_n;
  end
  always_comb begin
    state_n = arm ? ST_ARMED :
              (fill_done || post_done || (trig_hit && POST_TRIG == 0)) ? ST_DUMP :
              trig_hit ? ST_POST :
              (beat && out_last) ? ST_IDLE : state;
  end
  always_ff @(posedge MAX10_CLK1_50 or negedge KEY) begin
    if (!KEY) begin
      wr_ptr    <= '0;
      count     <= '0;
      triggered <= 1'b0;
      wrapped   <= 1'b0;
      post_cnt  <= '0;
      idx       <= '0;
      mode_r    <= MODE_STOP;
      trig_en_r <= 1'b0;
      trig_pc_r <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else if (arm) begin
      wr_ptr    <= '0;
      count     <= '0;
      triggered <= 1'b0;
      wrapped   <= 1'b0;
      post_cnt  <= '0;
      idx       <= '0;
      mode_r    <= mode;
      trig_en_r <= trig_en;
      trig_pc_r <= trig_pc;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      if (we) begin
        wr_ptr  <= wr_ptr + 1'b1;
        count   <= full ? count : count + 1'b1;
        wrapped <= wrapped | full;
        if (trig_hit) begin
          triggered <= 1'b1;
          post_cnt  <= AW'(POST_TRIG);
        end
        if (state == ST_POST) post_cnt <= post_cnt - 1'b1;
      end
      if (rd_en) begin
        idx       <= idx + 1'b1;
        out_valid <= 1'b1;
        out_last  <= idx + 1'b1 == count;
      end else if (beat) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_mips_trace_buffer.sv
// tb_mips_trace_buffer: scenario tasks plus randomized runs against a queue-based trace model
module tb_mips_trace_buffer;
  logic clk = 1'b0, KEY = 1'b0, cap_valid = 1'b0, arm = 1'b0, mode = 1'b0, trig_en = 1'b0, out_ready = 1'b0;
  logic [31:0] cap_pc = '0, cap_instr = '0, trig_pc = '0;
  logic out_valid, out_last, busy, triggered, wrapped;
  logic [31:0] out_pc, out_instr;
  logic [3:0] count;
  int tests_run = 0, fails = 0;
  logic [31:0] exp_q[$];
  logic [511:0] got_pk;
  int got_n, got_last_pos;
  mips_trace_buffer #(.ADDR_W(32), .DATA_W(32), .DEPTH(8), .POST_TRIG(3)) dut (
    .MAX10_CLK1_50(clk), .KEY(KEY), .cap_valid(cap_valid), .cap_pc(cap_pc), .cap_instr(cap_instr),
    .arm(arm), .mode(mode), .trig_en(trig_en), .trig_pc(trig_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr), .out_last(out_last),
    .busy(busy), .triggered(triggered), .wrapped(wrapped), .count(count)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return {pc[15:0], ~pc[15:0]} ^ 32'h2400_0000;
  endfunction
  function automatic logic [511:0] pack_exp();
    logic [511:0] p = '0;
    foreach (exp_q[i]) if (i < 8) p[i*64 +: 64] = {exp_q[i], instr_of(exp_q[i])};
    return p;
  endfunction
  task automatic do_arm(input logic m, input logic te, input logic [31:0] tpc);
    arm = 1'b1; mode = m; trig_en = te; trig_pc = tpc;
    @(negedge clk);
    arm = 1'b0;
  endtask
  task automatic capture(input logic [31:0] pc);
    cap_valid = 1'b1; cap_pc = pc; cap_instr = instr_of(pc);
    @(negedge clk);
    cap_valid = 1'b0;
  endtask
  task automatic collect(input int start);
    int n = start;
    bit seen_last = 1'b0;
    if (start == 0) got_pk = '0;
    got_last_pos = -1;
    out_ready = 1'b1;
    for (int c = 0; c < 100 && !seen_last; c++) begin
      if (out_valid) begin
        if (n < 8) got_pk[n*64 +: 64] = {out_pc, out_instr};
        if (out_last) begin
          got_last_pos = n;
          seen_last = 1'b1;
        end
        n++;
      end
      @(negedge clk);
    end
    got_n = n;
    out_ready = 1'b0;
  endtask
  task automatic test_reset();
    #3;
    tests_run++;
    if ({busy, triggered, wrapped, count, out_valid, out_last, out_pc, out_instr} !== '0) begin
      fails++; $display("FAIL reset_initial: outputs=%h required 0", {busy, triggered, wrapped, count, out_valid, out_last, out_pc, out_instr});
    end
    @(negedge clk); KEY = 1'b1; @(negedge clk);
    do_arm(1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 5; i++) capture(32'(i * 4));
    tests_run++;
    if ({busy, count} !== {1'b1, 4'd5}) begin
      fails++; $display("FAIL capture_before_reset: busy=%b count=%0d required busy=1 count=5", busy, count);
    end
    KEY = 1'b0;
    #1;
    tests_run++;
    if ({busy, triggered, wrapped, count, out_valid, out_last, out_pc, out_instr} !== '0) begin
      fails++; $display("FAIL reset_async: outputs=%h required 0", {busy, triggered, wrapped, count, out_valid, out_last, out_pc, out_instr});
    end
    @(negedge clk); KEY = 1'b1;
    @(negedge clk);
    capture(32'h20); capture(32'h24);
    tests_run++;
    if ({busy, count} !== 5'd0) begin
      fails++; $display("FAIL no_arm_after_reset: busy=%b count=%0d required busy=0 count=0", busy, count);
    end
  endtask
  task automatic test_fill_once();
    do_arm(1'b1, 1'b1, 32'h8);
    for (int i = 0; i < 10; i++) capture(32'(i * 4));
    tests_run++;
    if ({busy, triggered, wrapped, count} !== {1'b1, 1'b0, 1'b0, 4'd8}) begin
      fails++; $display("FAIL fill_once_status: busy=%b trig=%b wrap=%b count=%0d required 1 0 0 8", busy, triggered, wrapped, count);
    end
    exp_q = {};
    for (int i = 0; i < 8; i++) exp_q.push_back(32'(i * 4));
    collect(0);
    tests_run++;
    if (got_pk !== pack_exp() || got_n != exp_q.size() || got_last_pos != exp_q.size() - 1) begin
      fails++; $display("FAIL fill_once_dump: got %0d beats last@%0d data=%h required %0d beats data=%h", got_n, got_last_pos, got_pk, exp_q.size(), pack_exp());
    end
    tests_run++;
    if ({out_valid, busy, count} !== {1'b0, 1'b0, 4'd8}) begin
      fails++; $display("FAIL fill_once_after: valid=%b busy=%b count=%0d required 0 0 8", out_valid, busy, count);
    end
  endtask
  task automatic test_trigger_wrap();
    do_arm(1'b0, 1'b1, 32'h40);
    for (int i = 0; i <= 24; i++) capture(32'(i * 4));
    tests_run++;
    if ({busy, triggered, wrapped, count} !== {1'b1, 1'b1, 1'b1, 4'd8}) begin
      fails++; $display("FAIL trigger_wrap_status: busy=%b trig=%b wrap=%b count=%0d required 1 1 1 8", busy, triggered, wrapped, count);
    end
    exp_q = {};
    for (int i = 12; i < 20; i++) exp_q.push_back(32'(i * 4));
    collect(0);
    tests_run++;
    if (got_pk !== pack_exp() || got_n != exp_q.size() || got_last_pos != exp_q.size() - 1) begin
      fails++; $display("FAIL trigger_wrap_dump: got %0d beats last@%0d data=%h required %0d beats data=%h", got_n, got_last_pos, got_pk, exp_q.size(), pack_exp());
    end
  endtask
  task automatic test_trigger_first();
    do_arm(1'b0, 1'b1, 32'h0);
    for (int i = 0; i < 8; i++) capture(32'(i * 4));
    tests_run++;
    if ({busy, triggered, wrapped, count} !== {1'b1, 1'b1, 1'b0, 4'd4}) begin
      fails++; $display("FAIL trigger_first_status: busy=%b trig=%b wrap=%b count=%0d required 1 1 0 4", busy, triggered, wrapped, count);
    end
    exp_q = {32'h0, 32'h4, 32'h8, 32'hC};
    collect(0);
    tests_run++;
    if (got_pk !== pack_exp() || got_n != exp_q.size() || got_last_pos != exp_q.size() - 1) begin
      fails++; $display("FAIL trigger_first_dump: got %0d beats last@%0d data=%h required %0d beats data=%h", got_n, got_last_pos, got_pk, exp_q.size(), pack_exp());
    end
  endtask
  task automatic test_stall();
    do_arm(1'b1, 1'b0, 32'h0);
    exp_q = {};
    for (int i = 0; i < 8; i++) exp_q.push_back(32'h100 + 32'(i * 4));
    foreach (exp_q[i]) capture(exp_q[i]);
    for (int c = 0; c < 10 && !out_valid; c++) @(negedge clk);
    tests_run++;
    if (out_valid !== 1'b1) begin
      fails++; $display("FAIL stall_start: out_valid=%b required 1", out_valid);
    end
    got_pk = '0;
    got_pk[63:0] = {out_pc, out_instr};
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      tests_run++;
      if ({out_valid, out_pc, out_instr} !== {1'b1, exp_q[1], instr_of(exp_q[1])}) begin
        fails++; $display("FAIL stall_hold cycle %0d: valid=%b pc=%h instr=%h required 1 %h %h", c, out_valid, out_pc, out_instr, exp_q[1], instr_of(exp_q[1]));
      end
    end
    collect(1);
    tests_run++;
    if (got_pk !== pack_exp() || got_n != exp_q.size() || got_last_pos != exp_q.size() - 1) begin
      fails++; $display("FAIL stall_dump: got %0d beats last@%0d data=%h required %0d beats data=%h", got_n, got_last_pos, got_pk, exp_q.size(), pack_exp());
    end
  endtask
  task automatic test_abort();
    do_arm(1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 8; i++) capture(32'h200 + 32'(i * 4));
    for (int c = 0; c < 10 && !out_valid; c++) @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    arm = 1'b1; mode = 1'b0; trig_en = 1'b0;
    @(negedge clk);
    arm = 1'b0; out_ready = 1'b0;
    tests_run++;
    if ({out_valid, busy, triggered, wrapped, count} !== {1'b0, 1'b1, 1'b0, 1'b0, 4'd0}) begin
      fails++; $display("FAIL abort_status: valid=%b busy=%b trig=%b wrap=%b count=%0d required 0 1 0 0 0", out_valid, busy, triggered, wrapped, count);
    end
    capture(32'h300); capture(32'h304);
    tests_run++;
    if ({busy, count} !== {1'b1, 4'd2}) begin
      fails++; $display("FAIL abort_rearmed: busy=%b count=%0d required 1 2", busy, count);
    end
  endtask
  task automatic test_random();
    logic [31:0] caps[$];
    for (int it = 0; it < 16; it++) begin
      logic m, te, exp_trig, exp_wrap;
      logic [31:0] tpc;
      int n, t, last, cnt;
      bit done;
      m = 1'($urandom_range(0, 1));
      te = 1'($urandom_range(0, 1));
      tpc = 32'($urandom_range(0, 15) * 4);
      n = int'($urandom_range(1, 20));
      caps = {};
      for (int i = 0; i < n; i++) caps.push_back(32'($urandom_range(0, 15) * 4));
      t = -1;
      if (!m && te) for (int i = 0; i < n; i++) if (t < 0 && caps[i] == tpc) t = i;
      if (m) begin
        done = n >= 8;
        last = done ? 7 : n - 1;
      end else begin
        done = t >= 0 && t + 3 < n;
        last = done ? t + 3 : n - 1;
      end
      cnt = last + 1 > 8 ? 8 : last + 1;
      exp_trig = t >= 0;
      exp_wrap = !m && last + 1 > 8;
      exp_q = {};
      if (done) for (int i = last + 1 - cnt; i <= last; i++) exp_q.push_back(caps[i]);
      do_arm(m, te, tpc);
      foreach (caps[i]) capture(caps[i]);
      tests_run++;
      if ({busy, triggered, wrapped, count} !== {1'b1, exp_trig, exp_wrap, 4'(cnt)}) begin
        fails++; $display("FAIL random_status it %0d: busy=%b trig=%b wrap=%b count=%0d required 1 %b %b %0d", it, busy, triggered, wrapped, count, exp_trig, exp_wrap, cnt);
      end
      if (done) begin
        collect(0);
        tests_run++;
        if (got_pk !== pack_exp() || got_n != exp_q.size() || got_last_pos != exp_q.size() - 1 || busy !== 1'b0) begin
          fails++; $display("FAIL random_dump it %0d: got %0d beats last@%0d busy=%b data=%h required %0d beats data=%h", it, got_n, got_last_pos, busy, got_pk, exp_q.size(), pack_exp());
        end
      end
    end
  endtask
  initial begin
    test_reset();
    test_fill_once();
    test_trigger_wrap();
    test_trigger_first();
    test_stall();
    test_abort();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end
endmodule
